// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg -- shared definitions for the serial-to-parallel deserializer.
//
// Contents:
//   state_t        : FSM state encoding (IDLE / SHIFT / PARITY)
//   DEFAULT_WIDTH  : default parallel word width
//
// The PARITY state is only entered when the design is built with the
// SIPO_PARITY_EN macro defined.
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_bitcnt.sv
// -----------------------------------------------------------------------------
// sipo_bitcnt -- loadable bit counter with terminal-count flag.
//
// Parameters:
//   WIDTH : number of data bits per word; tc is high while the count equals
//           WIDTH-1, i.e. the bit being presented is the last data bit.
//   CW    : counter width, clog2(WIDTH+1) so the count can also hold WIDTH
//           (used while waiting for a parity bit).
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset, clears the count
//   load     in  : load load_val (has priority over inc)
//   load_val in  : value to load
//   inc      in  : increment the count
//   tc       out : terminal-count flag
// -----------------------------------------------------------------------------
module sipo_bitcnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser -- serial-in / parallel-out deserializer with a one-word output
// register, ready/valid handshake and sticky overrun flag.
//
// Bits are assembled LSB first. A completed word is copied into the output
// register at the edge that consumes its last bit, so pout_valid is visible
// one cycle after that bit was presented. If the output register is still
// occupied and not being accepted, the new word is dropped and overrun sets.
//
// Optional feature: define SIPO_PARITY_EN to append one even-parity bit to
// every frame; parity_err then flags words whose data XOR parity is 1.
// Without the macro, frames are WIDTH bits and parity_err is tied to 0.
//
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   sin_valid  in  : qualifies sin
//   sin        in  : serial data bit
//   pout       out : assembled parallel word [WIDTH-1:0]
//   pout_valid out : pout holds an unaccepted word
//   pout_ready in  : consumer accepts when pout_valid && pout_ready
//   overrun    out : sticky, a completed word was dropped
//   parity_err out : parity failure on the word in pout
// -----------------------------------------------------------------------------
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt_load_val;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_tc;
    logic             shift_en;
    logic             complete;
    logic             out_free;
`ifdef SIPO_PARITY_EN
    logic             perr_nxt;
`endif

    sipo_bitcnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .tc       (cnt_tc)
    );

    // Right shift: after WIDTH shifts the first bit sits in bit 0.
    assign sreg_shifted = {sin, sreg[WIDTH-1:1]};

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_inc      = 1'b0;
        shift_en     = 1'b0;
        complete     = 1'b0;
        word         = sreg_shifted;
`ifdef SIPO_PARITY_EN
        perr_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sin_valid) begin
                    shift_en     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(1);
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    shift_en = 1'b1;
                    if (cnt_tc) begin
`ifdef SIPO_PARITY_EN
                        cnt_inc   = 1'b1;
                        state_nxt = PARITY;
`else
                        complete  = 1'b1;
                        cnt_load  = 1'b1;
                        state_nxt = IDLE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                // Parity bit is not shifted in; the data is already aligned.
                if (sin_valid) begin
                    complete  = 1'b1;
                    word      = sreg;
                    perr_nxt  = (^sreg) ^ sin;
                    cnt_load  = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            if (shift_en) begin
                sreg <= sreg_shifted;
            end
        end
    end

    // A completed word may load if the register is empty or being drained
    // in this same cycle.
    assign out_free = !pout_valid || pout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (out_free) begin
                pout       <= word;
                pout_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (complete && out_free) begin
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser -- self-checking bench for sipo_deser (WIDTH = 4).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the rising edge where the DUT updates.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin_valid;
    logic         sin;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready;
    logic         overrun;
    logic         parity_err;

    int n_cmp  = 0;
    int n_fail = 0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin_valid  (sin_valid),
        .sin        (sin),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;      // data[0] is sent first
        logic         pbit;      // parity bit (used only with SIPO_PARITY_EN)
        logic         gaps;      // insert a sin_valid-low cycle between bits
        logic [W-1:0] exp_pout;
        logic         exp_perr;  // expected parity_err with SIPO_PARITY_EN
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one frame. Leaves the final bit on the inputs; it is consumed at
    // the next rising edge. ready_last raises pout_ready together with the
    // final bit of the frame.
    task automatic send_frame(input logic [W-1:0] d, input logic p,
                              input logic gaps, input logic ready_last);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            sin_valid = 1'b1;
            sin       = d[i];
`ifndef SIPO_PARITY_EN
            if (i == W - 1 && ready_last) pout_ready = 1'b1;
`endif
            if (gaps && i < W - 1) begin
                @(negedge clk);
                sin_valid = 1'b0;
                sin       = ~sin;
            end
        end
`ifdef SIPO_PARITY_EN
        if (gaps) begin
            @(negedge clk);
            sin_valid = 1'b0;
        end
        @(negedge clk);
        sin_valid = 1'b1;
        sin       = p;
        if (ready_last) pout_ready = 1'b1;
`else
        if (p) begin end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] ep,
                                 input logic ev, input logic eo, input logic ee);
        check({tag, ".pout"},       32'(pout),       32'(ep));
        check({tag, ".pout_valid"}, 32'(pout_valid), 32'(ev));
        check({tag, ".overrun"},    32'(overrun),    32'(eo));
        check({tag, ".parity_err"}, 32'(parity_err), 32'(ee));
    endtask

    initial begin
        logic exp_e;

        vecs[0] = '{4'b1101, 1'b1, 1'b0, 4'b1101, 1'b0};
        vecs[1] = '{4'b1101, 1'b1, 1'b1, 4'b1101, 1'b0};
        vecs[2] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1};
        vecs[4] = '{4'b1001, 1'b1, 1'b1, 4'b1001, 1'b1};
        vecs[5] = '{4'b0011, 1'b1, 1'b0, 4'b0011, 1'b1};
        vecs[6] = '{4'b0011, 1'b0, 1'b0, 4'b0011, 1'b0};
        vecs[7] = '{4'b0110, 1'b0, 1'b1, 4'b0110, 1'b0};

        rst        = 1'b1;
        sin_valid  = 1'b0;
        sin        = 1'b0;
        pout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table: each frame with pout_ready held high.
        for (int v = 0; v < 8; v++) begin
`ifdef SIPO_PARITY_EN
            exp_e = vecs[v].exp_perr;
`else
            exp_e = 1'b0;
`endif
            send_frame(vecs[v].data, vecs[v].pbit, vecs[v].gaps, 1'b0);
            @(negedge clk);
            sin_valid = 1'b0;
            check($sformatf("vec%0d.pout", v),       32'(pout),       32'(vecs[v].exp_pout));
            check($sformatf("vec%0d.valid", v),      32'(pout_valid), 32'd1);
            check($sformatf("vec%0d.parity_err", v), 32'(parity_err), 32'(exp_e));
            @(negedge clk);
            check($sformatf("vec%0d.valid_drop", v), 32'(pout_valid), 32'd0);
        end

        // Back-to-back frames, sin_valid continuously high: second word must
        // arrive exactly one frame later with no gap cycle.
        send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0111, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        sin_valid = 1'b0;
        check("b2b.pout",  32'(pout),       32'h7);
        check("b2b.valid", 32'(pout_valid), 32'd1);

        // Overrun: A then 5 with the consumer stalled.
        do_reset();
        pout_ready = 1'b0;
        send_frame(4'hA, 1'b0, 1'b0, 1'b0);
        send_frame(4'h5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sin_valid = 1'b0;
        check_outputs("ovr", 4'hA, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_outputs("ovr_hold", 4'hA, 1'b1, 1'b1, 1'b0);
        pout_ready = 1'b1;
        @(negedge clk);
        check_outputs("ovr_drain", 4'hA, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("ovr_no_second.valid", 32'(pout_valid), 32'd0);

        // Handshake in the same cycle the second word completes.
        do_reset();
        pout_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b0, 1'b0);
        send_frame(4'hC, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        sin_valid  = 1'b0;
        pout_ready = 1'b0;
        check_outputs("same_cycle", 4'hC, 1'b1, 1'b0, 1'b0);
        pout_ready = 1'b1;
        @(negedge clk);

        // Reset mid-word, with sin_valid high during reset.
        do_reset();
        @(negedge clk);
        sin_valid = 1'b1;
        sin       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sin_valid = 1'b0;
        check_outputs("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sin_valid = 1'b0;
        check_outputs("after_rst", 4'b0110, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
